delay_line_ctrl: RTL
====================

Name: delay_line_ctrl

Overview:
- Circular-buffer controller that drives an external simple dual-port RAM: one write port, one read port, 1-cycle registered read, read-old-data on an address collision.
- Writes each incoming sample at a write pointer.
- Reads back the sample written DELAY samples earlier, so the block acts as a programmable sample delay line.
- Sits between the sample source (ROM/ADC path) and the output stage; acts as the reader/writer on the RAM's port side.

Parameters:
- ADDRESS_WIDTH, 9, RAM address width; buffer depth is 2**ADDRESS_WIDTH.
- DATA_WIDTH, 8, sample width.

Ports:
- clk  input  1  clock; everything is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cfg_load  input  1  one-cycle pulse; latches delay_in and restarts the fill.
- delay_in  input  ADDRESS_WIDTH  requested delay in samples.
- sample_valid  input  1  strobe; sample_in is valid this cycle.
- sample_in  input  DATA_WIDTH  input sample.
- ram_wr_en  output  1  RAM write enable.
- ram_rd_en  output  1  RAM read enable.
- ram_wr_addr  output  ADDRESS_WIDTH  RAM write address.
- ram_rd_addr  output  ADDRESS_WIDTH  RAM read address.
- ram_din  output  DATA_WIDTH  RAM write data.
- ram_dout  input  DATA_WIDTH  RAM read data, valid the cycle after ram_rd_en.
- out_valid  output  1  sample_out is valid.
- sample_out  output  DATA_WIDTH  delayed sample.
- filling  output  1  high while the buffer holds fewer than delay_q samples.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - wr_ptr=0, fill_cnt=0, delay_q=0, state=FILL
  - all ram_* outputs=0, out_valid=0, sample_out=0, filling=0 (filling is forced low because delay_q=0)
  - pipeline valids cleared.
- Reset mid-operation drops any in-flight sample; no out_valid for it.
- cfg_load:
  - delay_q<=delay_in, fill_cnt<=0, state<=FILL. wr_ptr is not reset.
  - cfg_load has priority over a simultaneous sample_valid. That sample is still written and counted against the new delay, so fill_cnt=1 after that cycle.
- Pipeline, for sample_valid at cycle N:
  - N+1 (issue):
    - ram_wr_en=1, ram_wr_addr=wr_ptr, ram_din=sample
    - ram_rd_en=1, ram_rd_addr=(wr_ptr-delay_q) mod 2**ADDRESS_WIDTH
    - wr_ptr increments, wrapping from 2**ADDRESS_WIDTH-1 to 0.
  - N+2 (result): out_valid=1 for one cycle; sample_out as defined below.
  - Latency is fixed at 2 cycles. Throughput is one sample per cycle (back-to-back sample_valid is legal).
  - ram_wr_en and ram_rd_en are 0 on cycles with no issue; addresses and din hold their last values.
- Result selection at N+2:
  - delay_q==0 (bypass): sample_out = the sample itself, taken from an internal 2-stage register, not from the RAM. The RAM read of the same address returns old data, so it is not used.
  - state==FILL at issue time: sample_out=0 (silence until the buffer holds delay_q samples).
  - Otherwise: sample_out = ram_dout.
- State machine:
  - FILL: each issued sample increments fill_cnt. When fill_cnt reaches delay_q-1 at an issue, go to RUN; the next issued sample reads real data.
  - delay_q==0 goes straight to RUN on the next cycle.
  - RUN: steady state; fill_cnt is held.
  - filling=1 exactly while state==FILL and delay_q!=0.
- Boundaries:
  - delay_q=2**ADDRESS_WIDTH-1 is the maximum and is legal.
  - Read and write addresses never collide except at delay 0.
  - Pointer subtraction is modulo 2**ADDRESS_WIDTH, with no sign extension.

Optional Feature:
- DELAY_MIX_EN defined:
  - In RUN, sample_out = (sample_in_delayed2 + ram_dout) >> 1, i.e. an echo mix of dry and delayed.
  - Computed at DATA_WIDTH+1 bits, then truncated; unsigned.
  - In FILL, sample_out = sample_in_delayed2 >> 1.
  - Bypass (delay 0) is unchanged.
- Undefined: sample_out is the pure delayed sample as above; no adder is instantiated.

Test Plan:
- Reset, then cfg_load with delay_in=3, then samples 10,20,30,40,50 back-to-back. Required:
  - ram_wr_addr 0..4
  - sample_out 0,0,0,10,20, each 2 cycles after its input
  - filling falls after the 3rd issue.
- delay_in=0 with samples 5,6,7 -> sample_out 5,6,7 with 2-cycle latency; filling never asserts.
- delay_in=4 with 600 samples, values i mod 256 -> ram_wr_addr wraps 511->0. After the fill, sample_out(i)=(i-4) mod 256, including across the wrap (ram_rd_addr 510,511,0,...).
- Gapped input: samples on every 3rd cycle -> ram_wr_en/ram_rd_en high only on issue cycles; out_valid pulses match one-to-one.
- In RUN with delay 3, cfg_load delay_in=2 simultaneous with sample 99:
  - 99 is written; fill_cnt=1 afterwards
  - the 99 result is 0 (FILL), the next result is 0, after which filling=0
  - outputs resume with 99 at the second result after that.
- Reset asserted on the cycle after a sample_valid -> no out_valid follows; wr_ptr=0; the next sample is written to address 0.
- DELAY_MIX_EN build, delay 1, samples 100,200 -> sample_out 50 (FILL, 100>>1), then 150.

Source files
------------

// File: rtl/delay_line_ctrl.sv
// Circular-buffer sample delay line controller for an external SDP RAM.
// Optional echo mix of dry and delayed samples: define DELAY_MIX_EN.
module delay_line_ctrl #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_load,
    input  logic [ADDRESS_WIDTH-1:0] delay_in,
    input  logic                     sample_valid,
    input  logic [DATA_WIDTH-1:0]    sample_in,
    output logic                     ram_wr_en,
    output logic                     ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    sample_out,
    output logic                     filling
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [AW-1:0]   delay_q, delay_d;

    // Issue stage: RAM port registers plus result-selection tags
    logic            wr_en_q, wr_en_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            iss_byp_q, iss_byp_d;
    logic            iss_fill_q, iss_fill_d;

    // Result stage: aligned with ram_dout
    logic            res_valid_q, res_valid_d;
    logic            res_byp_q, res_byp_d;
    logic            res_fill_q, res_fill_d;
    logic [DW-1:0]   dry2_q, dry2_d;

    // Values as seen by this cycle's issue, after a possible cfg_load
    logic [AW-1:0]   eff_delay;
    logic [AW-1:0]   eff_cnt;
    state_t          eff_state;

    // Next-state, pointer and pipeline logic
    always_comb begin
        eff_delay   = cfg_load ? delay_in : delay_q;
        eff_cnt     = cfg_load ? '0 : fill_cnt_q;
        eff_state   = cfg_load ? FILL : state_q;

        state_d     = eff_state;
        fill_cnt_d  = eff_cnt;
        delay_d     = eff_delay;
        wr_ptr_d    = wr_ptr_q;

        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        din_d       = din_q;
        iss_byp_d   = iss_byp_q;
        iss_fill_d  = iss_fill_q;

        res_valid_d = wr_en_q;
        res_byp_d   = iss_byp_q;
        res_fill_d  = iss_fill_q;
        dry2_d      = wr_en_q ? din_q : dry2_q;

        // A zero delay needs no fill phase
        if (!cfg_load && state_q == FILL && delay_q == '0) begin
            state_d = RUN;
        end

        if (sample_valid) begin
            wr_en_d    = 1'b1;
            rd_en_d    = 1'b1;
            wr_addr_d  = wr_ptr_q;
            rd_addr_d  = wr_ptr_q - eff_delay;
            din_d      = sample_in;
            wr_ptr_d   = wr_ptr_q + ONE;
            iss_byp_d  = (eff_delay == '0);
            iss_fill_d = (eff_state == FILL);
            if (eff_state == FILL && eff_delay != '0) begin
                fill_cnt_d = eff_cnt + ONE;
                if (eff_cnt == eff_delay - ONE) begin
                    state_d = RUN;
                end
            end
        end
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            delay_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            din_q       <= '0;
            iss_byp_q   <= 1'b0;
            iss_fill_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_byp_q   <= 1'b0;
            res_fill_q  <= 1'b0;
            dry2_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            delay_q     <= delay_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            din_q       <= din_d;
            iss_byp_q   <= iss_byp_d;
            iss_fill_q  <= iss_fill_d;
            res_valid_q <= res_valid_d;
            res_byp_q   <= res_byp_d;
            res_fill_q  <= res_fill_d;
            dry2_q      <= dry2_d;
        end
    end

`ifdef DELAY_MIX_EN
    logic [DW:0] mix_sum;
    assign mix_sum = {1'b0, dry2_q} + {1'b0, ram_dout};
`endif

    // Result select: ram_dout is only valid in this cycle, so it is muxed live
    always_comb begin
        sample_out = '0;
        if (res_valid_q) begin
            if (res_byp_q) begin
                sample_out = dry2_q;
            end else if (res_fill_q) begin
`ifdef DELAY_MIX_EN
                sample_out = dry2_q >> 1;
`else
                sample_out = '0;
`endif
            end else begin
`ifdef DELAY_MIX_EN
                sample_out = mix_sum[DW:1];
`else
                sample_out = ram_dout;
`endif
            end
        end
    end

    assign ram_wr_en   = wr_en_q;
    assign ram_rd_en   = rd_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_rd_addr = rd_addr_q;
    assign ram_din     = din_q;
    assign out_valid   = res_valid_q;
    assign filling     = (state_q == FILL) && (delay_q != '0);

endmodule
